// File: rtl/data_mem_responder.sv
// Data-memory responder: serves single read/write requests from an internal word array over a four-phase req/ack handshake.
// Latency: ack pulses for one cycle, WAIT_STATES edges after the capture edge (same edge when WAIT_STATES=0).
// Backpressure: req held past ack parks the block in DONE; no new request is taken until req is seen low.
module data_mem_responder #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic              SysCLK,
    input  logic              SysRST,
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   cap_addr;
    logic                cap_rnw;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                resp_enter;
    logic [ADDR_W-1:0]   eff_addr;
    logic                eff_rnw;
    logic [DATA_W-1:0]   eff_wdata;
    logic                eff_oor;
    logic [IDX_W-1:0]    eff_idx;

    // State register.
    always_ff @(posedge SysCLK or posedge SysRST) begin
        if (SysRST) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: count wait states, one-cycle response, then hold off until req falls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = req ? S_DONE : S_IDLE;
            S_DONE:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs/decode: with zero wait states the response uses the live inputs, otherwise the captured copy.
    always_comb begin
        busy       = (state_q != S_IDLE);
        accept     = (state_q == S_IDLE) && req;
        resp_enter = (state_d == S_RESP);
        eff_addr   = accept ? addr  : cap_addr;
        eff_rnw    = accept ? rnw   : cap_rnw;
        eff_wdata  = accept ? wdata : cap_wdata;
        eff_oor    = ({1'b0, eff_addr} >= DEPTH_LIM);
        eff_idx    = eff_addr[IDX_W-1:0];
    end

    // Request capture and wait-state counter; inputs are ignored once captured.
    always_ff @(posedge SysCLK or posedge SysRST) begin
        if (SysRST) begin
            cnt_q     <= '0;
            cap_addr  <= '0;
            cap_rnw   <= 1'b0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt_q     <= CNT_LOAD;
            cap_addr  <= addr;
            cap_rnw   <= rnw;
            cap_wdata <= wdata;
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Registered response strobe; data, drive enable and error are zero outside the ack cycle.
    always_ff @(posedge SysCLK or posedge SysRST) begin
        if (SysRST) begin
            ack      <= 1'b0;
            rdata    <= '0;
            rdata_oe <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack      <= resp_enter;
            err      <= resp_enter & eff_oor;
            rdata_oe <= resp_enter & eff_rnw;
            rdata    <= (resp_enter && eff_rnw && !eff_oor) ? mem[eff_idx] : '0;
        end
    end

    // Word array: writes commit on the edge that enters RESP, and only for in-range addresses.
    always_ff @(posedge SysCLK or posedge SysRST) begin
        if (SysRST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (resp_enter && !eff_rnw && !eff_oor) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

endmodule
